jk_latch: RTL and testbench

JK_LATCH -- requirements
Module: jk_latch

---
 rtl/jk_latch.sv | 50 +++++
 tb/tb_jk_latch.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/jk_latch.sv
// jk_latch: rising-edge JK flip-flop with a synchronous active-high reset.
// Despite the name, the state changes only on the rising edge of clk. The
// state bit powers up at INIT_VALUE, so toggle mode is defined even before
// the first reset.
module jk_latch #(
    parameter logic RESET_VALUE = 1'b0,
    parameter logic INIT_VALUE  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    // Single state bit. The declaration initialiser gives the time-zero value
    // in simulation and the bitstream init value on FPGAs.
    logic state_q = INIT_VALUE;
    logic state_d;

    // Next-state selection. Reset wins over every j/k pair.
    // An X or Z on rst makes the if condition false, so it is treated as
    // deasserted in simulation.
    always_comb begin
        state_d = state_q;
        if (rst) begin
            state_d = RESET_VALUE;
        end else begin
            unique case ({j, k})
                2'b00:   state_d = state_q;   // hold
                2'b10:   state_d = 1'b1;      // set
                2'b01:   state_d = 1'b0;      // clear
                2'b11:   state_d = ~state_q;  // toggle, once per edge
                default: state_d = state_q;
            endcase
        end
    end

    // State register. This is the only place q can change, so there is no
    // race-around and no combinational path from the inputs to the outputs.
    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    // Both outputs come straight from the flop, so qbar is always ~q.
    assign q    = state_q;
    assign qbar = ~state_q;

endmodule

// File: tb/tb_jk_latch.sv
// Directed testbench for jk_latch. Inputs change on falling edges and the
// outputs are sampled 1 ns after each rising edge.
// Instance u_a uses the default parameters.
// Instance u_b uses RESET_VALUE=1 and checks reset priority with j=0, k=1.
module tb_jk_latch;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic j = 1'b0;
    logic k = 1'b0;
    logic qa, qbara, qb, qbarb;

    int n_vec  = 0;
    int n_fail = 0;

    always #10 clk = ~clk;

    jk_latch u_a (
        .clk  (clk),
        .rst  (rst_a),
        .j    (j),
        .k    (k),
        .q    (qa),
        .qbar (qbara)
    );

    jk_latch #(.RESET_VALUE(1'b1), .INIT_VALUE(1'b0)) u_b (
        .clk  (clk),
        .rst  (rst_b),
        .j    (j),
        .k    (k),
        .q    (qb),
        .qbar (qbarb)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Checks q of instance A against the expected value, and qbar against its complement.
    task automatic chk_a(input string tag, input logic exp);
        chk({tag, ".q"}, qa, exp);
        chk({tag, ".qbar"}, qbara, ~exp);
    endtask

    // Drives the inputs on a falling edge, then checks instance A after the next rising edge.
    task automatic step(input logic jj, input logic kk, input logic ra,
                        input logic exp, input string tag);
        @(negedge clk);
        j = jj; k = kk; rst_a = ra;
        @(posedge clk);
        #1;
        chk_a(tag, exp);
    endtask

    initial begin
        // Power-up value before any edge or reset.
        #1;
        chk_a("init_a", 1'b0);
        chk("init_b.q", qb, 1'b0);
        chk("init_b.qbar", qbarb, 1'b1);

        // Synchronous reset.
        step(1'b0, 1'b0, 1'b1, 1'b0, "reset");

        // Basic JK table.
        step(1'b0, 1'b0, 1'b0, 1'b0, "hold0");
        step(1'b1, 1'b0, 1'b0, 1'b1, "set");
        step(1'b0, 1'b1, 1'b0, 1'b0, "clear");
        step(1'b1, 1'b1, 1'b0, 1'b1, "toggle");
        step(1'b0, 1'b0, 1'b0, 1'b1, "hold1");

        // Sustained toggle from q=0: exactly one transition per edge.
        step(1'b0, 1'b1, 1'b0, 1'b0, "pre_tog");
        step(1'b1, 1'b1, 1'b0, 1'b1, "tog1");
        step(1'b1, 1'b1, 1'b0, 1'b0, "tog2");
        step(1'b1, 1'b1, 1'b0, 1'b1, "tog3");
        step(1'b1, 1'b1, 1'b0, 1'b0, "tog4");

        // Reset overrides toggle, and toggling resumes on the next edge.
        step(1'b1, 1'b0, 1'b0, 1'b1, "pre_rst");
        step(1'b1, 1'b1, 1'b1, 1'b0, "rst_over_tog");
        step(1'b1, 1'b1, 1'b0, 1'b1, "tog_resume");

        // Reset pulse that does not span a rising edge has no effect.
        @(negedge clk);
        j = 1'b0; k = 1'b0;
        #3 rst_a = 1'b1;
        #3 rst_a = 1'b0;
        @(posedge clk);
        #1;
        chk_a("rst_glitch", 1'b1);

        // Reset sampled mid-cycle takes effect only at the edge.
        @(negedge clk);
        #4 rst_a = 1'b1;
        #1 chk_a("rst_mid_pre", 1'b1);
        @(posedge clk);
        #1;
        chk_a("rst_mid_post", 1'b0);

        // j pulse between edges does not change q.
        @(negedge clk);
        rst_a = 1'b0; j = 1'b0; k = 1'b0;
        #2 j = 1'b1;
        #3 j = 1'b0;
        @(posedge clk);
        #1;
        chk_a("j_pulse", 1'b0);

        // Set q to 1, then check that a k pulse between edges is ignored.
        step(1'b1, 1'b0, 1'b0, 1'b1, "set2");
        @(negedge clk);
        j = 1'b0; k = 1'b0;
        #2 k = 1'b1;
        #3 k = 1'b0;
        @(posedge clk);
        #1;
        chk_a("k_pulse", 1'b1);

        // Instance B: RESET_VALUE=1 takes priority over clear.
        @(negedge clk);
        j = 1'b0; k = 1'b1; rst_b = 1'b1;
        @(posedge clk);
        #1;
        chk("rstval1.q", qb, 1'b1);
        chk("rstval1.qbar", qbarb, 1'b0);
        chk_a("a_clear", 1'b0);

        // Instance B: normal operation resumes once rst falls.
        @(negedge clk);
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        chk("b_resume.q", qb, 1'b0);
        chk("b_resume.qbar", qbarb, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
